uart_baud_gen: RTL
==================

Name: uart_baud_gen

Overview:
Runtime-programmable fractional baud generator for the UART TX/RX datapaths. It produces three timing strobes from `clk`:
- an oversample tick
- a mid-bit sample tick
- a bit tick

The divisor has an integer part and a FRAC_W-bit fractional part, and the oversample ratio is set at run time. Reset defaults come from parameters. RX realigns phase on start-bit detect through `phase_sync`.

Parameters:
- CLOCK_FREQ, 50_000_000, system clock in Hz (reset default computation only).
- BAUD_RATE, 9600, reset-default baud rate in bps.
- OVERSAMPLE, 16, reset-default oversample ratio.
- DIV_INT_W, 16, width of the integer divisor.
- FRAC_W, 8, width of the fractional divisor and accumulator.
- OSR_W, 5, width of the oversample ratio.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  count enable; low freezes all state and suppresses ticks
- cfg_load  in  1  one-cycle pulse; capture cfg_* and restart phase
- cfg_div_int  in  DIV_INT_W  integer clocks per oversample tick
- cfg_div_frac  in  FRAC_W  fractional clocks per oversample tick, in units of 2^-FRAC_W
- cfg_osr  in  OSR_W  oversample ticks per bit
- phase_sync  in  1  restart phase without changing config
- os_tick  out  1  one-cycle oversample strobe
- mid_tick  out  1  one-cycle mid-bit strobe, always coincident with an os_tick
- bit_tick  out  1  one-cycle end-of-bit strobe, always coincident with an os_tick
- cfg_err  out  1  active config illegal; no ticks while high

Behaviour:
- Reset: all outputs 0; int_cnt, os_cnt and frac_acc are 0.
- Reset config values:
  - div_int = CLOCK_FREQ / (BAUD_RATE*OVERSAMPLE)
  - div_frac = (CLOCK_FREQ*2^FRAC_W)/(BAUD_RATE*OVERSAMPLE) - div_int*2^FRAC_W
  - osr = OVERSAMPLE
  - Elaboration fails if the defaults are illegal or do not fit their widths.
  - With the defaults (325, 133, 16), the block runs immediately after reset.
- Restart: a cfg_load, a phase_sync, or reset release loads int_cnt with div_int-1 and clears os_cnt and frac_acc.
- Counting, each enabled cycle when not restarting:
  - If int_cnt != 0, decrement it.
  - If int_cnt == 0:
    - Pulse os_tick in the next cycle (registered).
    - Compute {carry, frac_acc} = frac_acc + div_frac.
    - Reload int_cnt with div_int-1+carry.
- Timing:
  - With div_frac = 0 and N = div_int, os_tick pulses exactly every N cycles.
  - The first os_tick is high N cycles after the edge that sampled the restart.
  - N = 1 gives os_tick continuously high.
- Fractional accuracy: over any 2^FRAC_W consecutive os_ticks after a restart, total cycles = 2^FRAC_W*div_int + div_frac exactly. Wrap of frac_acc is modulo 2^FRAC_W.
- os_cnt:
  - Counts os_ticks from 0 to osr-1 and wraps to 0.
  - mid_tick accompanies the os_tick on which os_cnt == (osr>>1)-1. For osr = 16 this is the 8th os_tick after restart.
  - bit_tick accompanies the os_tick on which os_cnt == osr-1. For osr = 16 this is the 16th os_tick.
  - For odd osr, mid_tick uses floor(osr/2).
- cfg_load:
  - Captures all three cfg_* fields in the sampling cycle.
  - The new values take effect in the same restart.
  - Any tick that would have occurred in the following cycle is dropped.
- Priority: cfg_load > phase_sync > normal count. A restart coinciding with int_cnt == 0 produces no tick.
- en low:
  - All state holds and outputs are 0.
  - cfg_load and phase_sync still take effect.
  - When en returns high, counting resumes from the held state.
- cfg_err:
  - Registered; equals (div_int == 0) || (osr < 2) for the active config.
  - While high: counters hold in their restart state and all ticks are 0.
  - Cleared by a cfg_load with legal values.
- Simultaneous strobes: osr = 2 makes mid_tick and bit_tick fall on alternate os_ticks; they never coincide for osr >= 2.
- Reset mid-operation: everything returns to the reset defaults asynchronously, with no tick in the following cycle.

Decomposition:
- Package uart_pkg:
  - baud_cfg_t struct {div_int, div_frac, osr}
  - constant functions calc_div_int() and calc_div_frac() (shared with TX/RX benches)
  - widths DIV_INT_W, FRAC_W, OSR_W as package parameters
- Sub-module uart_frac_div: int_cnt plus frac_acc; outputs the raw os strobe.
- Top level: config registers, restart priority, os_cnt, mid/bit decode, cfg_err.

Test Plan:
- Reset release with defaults and en = 1 → over 256 os_ticks, total = 83333 cycles; bit_tick every 16th os_tick; mid_tick on the 8th.
- cfg_load div_int = 4, frac = 0, osr = 4 → os_tick every 4 cycles, the first 4 cycles after the load edge; bit_tick period 16 cycles; mid_tick at the 2nd os_tick.
- cfg_load div_int = 3, frac = 128 (FRAC_W = 8) → os_tick intervals alternate 3, 4, 3, 4, …
- phase_sync asserted on the same cycle int_cnt == 0 → no os_tick in the next cycle; the next os_tick follows div_int cycles later; os_cnt restarts, so mid_tick falls on the (osr>>1)th os_tick after the sync.
- en low for 10 cycles mid-interval → no ticks; after en returns high, the remaining interval completes with the held count, adding exactly 10 cycles of shift.
- cfg_load div_int = 0 → cfg_err = 1 with no ticks; then cfg_load div_int = 2, osr = 16 → cfg_err = 0 and os_tick every 2 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART timing types and reset-default divisor arithmetic,
// used by the baud generator and by the TX/RX benches.
package uart_pkg;

   parameter int DIV_INT_W = 16;
   parameter int FRAC_W    = 8;
   parameter int OSR_W     = 5;

   typedef struct packed {
      logic [DIV_INT_W-1:0] div_int;
      logic [FRAC_W-1:0]    div_frac;
      logic [OSR_W-1:0]     osr;
   } baud_cfg_t;

   function automatic longint unsigned calc_div_int(input int unsigned clock_freq,
                                                    input int unsigned baud_rate,
                                                    input int unsigned oversample);
      return longint'(clock_freq) / (longint'(baud_rate) * longint'(oversample));
   endfunction

   // 64-bit math: clock_freq << frac_w overflows 32 bits for common clocks
   function automatic longint unsigned calc_div_frac(input int unsigned clock_freq,
                                                     input int unsigned baud_rate,
                                                     input int unsigned oversample,
                                                     input int          frac_w);
      longint unsigned scaled;
      scaled = (longint'(clock_freq) << frac_w) / (longint'(baud_rate) * longint'(oversample));
      return scaled - (calc_div_int(clock_freq, baud_rate, oversample) << frac_w);
   endfunction

endpackage

// File: rtl/uart_frac_div.sv
// Fractional clock divider: integer down-counter plus fractional accumulator
// whose carry stretches an interval by one clock.
module uart_frac_div #(
   parameter int DIV_INT_W = 16,
   parameter int FRAC_W    = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 hold,
   input  logic                 restart,
   input  logic [DIV_INT_W-1:0] div_int,
   input  logic [FRAC_W-1:0]    div_frac,
   output logic                 os_strobe
);

   logic [DIV_INT_W-1:0] int_cnt_q, int_cnt_d;
   logic [FRAC_W-1:0]    frac_acc_q, frac_acc_d;
   logic                 strobe_q, strobe_d;
   logic [FRAC_W:0]      frac_sum;

   always_comb begin
      int_cnt_d  = int_cnt_q;
      frac_acc_d = frac_acc_q;
      strobe_d   = strobe_q;
      frac_sum   = {1'b0, frac_acc_q} + {1'b0, div_frac};
      if (restart) begin
         int_cnt_d  = div_int - 1'b1;
         frac_acc_d = '0;
         strobe_d   = 1'b0;
      end else if (en && !hold) begin
         if (int_cnt_q != '0) begin
            int_cnt_d = int_cnt_q - 1'b1;
            strobe_d  = 1'b0;
         end else begin
            strobe_d   = 1'b1;
            frac_acc_d = frac_sum[FRAC_W-1:0];
            int_cnt_d  = div_int - 1'b1 + DIV_INT_W'(frac_sum[FRAC_W]);
         end
      end
   end

   // A strobe pending while en is low is held and released when en returns
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         int_cnt_q  <= '0;
         frac_acc_q <= '0;
         strobe_q   <= 1'b0;
      end else begin
         int_cnt_q  <= int_cnt_d;
         frac_acc_q <= frac_acc_d;
         strobe_q   <= strobe_d;
      end
   end

   assign os_strobe = strobe_q;

endmodule

// File: rtl/uart_baud_gen.sv
// Runtime-programmable fractional baud generator: oversample, mid-bit and
// end-of-bit strobes with config capture, phase restart and config checking.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int unsigned CLOCK_FREQ = 50_000_000,
   parameter int unsigned BAUD_RATE  = 9600,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int          DIV_INT_W  = uart_pkg::DIV_INT_W,
   parameter int          FRAC_W     = uart_pkg::FRAC_W,
   parameter int          OSR_W      = uart_pkg::OSR_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 cfg_load,
   input  logic [DIV_INT_W-1:0] cfg_div_int,
   input  logic [FRAC_W-1:0]    cfg_div_frac,
   input  logic [OSR_W-1:0]     cfg_osr,
   input  logic                 phase_sync,
   output logic                 os_tick,
   output logic                 mid_tick,
   output logic                 bit_tick,
   output logic                 cfg_err
);

   localparam longint unsigned DEF_INT_L  = calc_div_int(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
   localparam longint unsigned DEF_FRAC_L = calc_div_frac(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE, FRAC_W);
   localparam logic [DIV_INT_W-1:0] DEF_DIV_INT  = DEF_INT_L[DIV_INT_W-1:0];
   localparam logic [FRAC_W-1:0]    DEF_DIV_FRAC = DEF_FRAC_L[FRAC_W-1:0];
   localparam logic [OSR_W-1:0]     DEF_OSR      = OVERSAMPLE[OSR_W-1:0];

   if (DEF_INT_L == 64'd0 || DEF_INT_L >= (64'd1 << DIV_INT_W) ||
       OVERSAMPLE < 32'd2 || OVERSAMPLE >= (32'd1 << OSR_W)) begin : g_bad_defaults
      $error("uart_baud_gen: reset-default divisor or oversample ratio is illegal");
   end

   logic [DIV_INT_W-1:0] div_int_q, div_int_d;
   logic [FRAC_W-1:0]    div_frac_q, div_frac_d;
   logic [OSR_W-1:0]     osr_q, osr_d;
   logic [OSR_W-1:0]     os_cnt_q, os_cnt_d;
   logic                 cfg_err_q, cfg_err_d;
   logic                 restart_pend_q;
   logic                 restart;
   logic                 os_raw;

   always_comb begin
      restart    = cfg_load | phase_sync | restart_pend_q;
      div_int_d  = div_int_q;
      div_frac_d = div_frac_q;
      osr_d      = osr_q;
      cfg_err_d  = cfg_err_q;
      if (cfg_load) begin
         div_int_d  = cfg_div_int;
         div_frac_d = cfg_div_frac;
         osr_d      = cfg_osr;
         cfg_err_d  = (cfg_div_int == '0) || (cfg_osr < OSR_W'(2));
      end
   end

   // Fed the next-state config so a load restarts with the new divisor
   uart_frac_div #(
      .DIV_INT_W (DIV_INT_W),
      .FRAC_W    (FRAC_W)
   ) u_frac_div (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .hold      (cfg_err_q),
      .restart   (restart),
      .div_int   (div_int_d),
      .div_frac  (div_frac_d),
      .os_strobe (os_raw)
   );

   always_comb begin
      os_tick  = os_raw & en & ~cfg_err_q;
      mid_tick = os_tick && (os_cnt_q == (osr_q >> 1) - 1'b1);
      bit_tick = os_tick && (os_cnt_q == osr_q - 1'b1);
      os_cnt_d = os_cnt_q;
      if (restart) begin
         os_cnt_d = '0;
      end else if (os_tick) begin
         os_cnt_d = (os_cnt_q == osr_q - 1'b1) ? '0 : os_cnt_q + 1'b1;
      end
   end

   // restart_pend_q turns the first edge after reset release into a restart
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_int_q      <= DEF_DIV_INT;
         div_frac_q     <= DEF_DIV_FRAC;
         osr_q          <= DEF_OSR;
         os_cnt_q       <= '0;
         cfg_err_q      <= 1'b0;
         restart_pend_q <= 1'b1;
      end else begin
         div_int_q      <= div_int_d;
         div_frac_q     <= div_frac_d;
         osr_q          <= osr_d;
         os_cnt_q       <= os_cnt_d;
         cfg_err_q      <= cfg_err_d;
         restart_pend_q <= 1'b0;
      end
   end

   assign cfg_err = cfg_err_q;

endmodule
